// File: rtl/ultimem_cfg_regs.sv
// Configuration register window at REG_BASE plus BLK1/2/3/5 mapper for the memory decoder.
// Optional build macro UNLOCK_SEQ_EN gates writes to registers 2-7 behind a CTRL key sequence.
module ultimem_cfg_regs #(
   parameter logic [7:0]  ID_VALUE = 8'h11,
   parameter logic [15:0] REG_BASE = 16'h9FF0,
   parameter int          BANK_W   = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              phi2_cpu,
   input  logic [15:0]       address_cpu,
   input  logic [7:0]        data_cpu_in,
   input  logic              r_w_cpu,
   output logic [7:0]        data_reg_out,
   output logic              data_reg_oe,
   output logic              map_ram,
   output logic              map_rom,
   output logic              map_wp,
   output logic [BANK_W-1:0] map_bank,
   output logic              hidden
);

   logic                       phi2_m, phi2_s, phi2_d;
   logic                       fall;
   logic [15:0]                hold_addr;
   logic [7:0]                 hold_data;
   logic                       hold_rw;
   logic [2:0]                 wsel;
   logic                       commit;
   logic                       key_wr;
   logic                       cfg_wr_en;
   logic [6:0]                 ctrl_q;
   logic [7:0]                 mode_q;
   logic [7:0]                 scratch_q;
   logic [3:0][BANK_W-1:0]     bank_q;
   logic [1:0]                 bank_wsel;
   logic                       win_hit;
   logic                       blk_vld;
   logic [1:0]                 blk_sel;
   logic [1:0]                 blk_mode;

   assign fall      = phi2_d & ~phi2_s;
   assign wsel      = hold_addr[2:0];
   assign commit    = fall & ~hold_rw & (hold_addr[15:3] == REG_BASE[15:3]) & ~hidden;
   // registers 3..6 map onto bank slots 0..3
   assign bank_wsel = wsel[1:0] + 2'd1;

`ifdef UNLOCK_SEQ_EN
   typedef enum logic [1:0] {LOCKED, KEY1, UNLOCKED} lock_t;
   lock_t lock_q;

   always_comb begin
      key_wr = 1'b0;
      if (wsel == 3'd0) begin
         case (lock_q)
            LOCKED:   key_wr = (hold_data == 8'hA5);
            KEY1:     key_wr = (hold_data == 8'h5A);
            UNLOCKED: key_wr = (hold_data == 8'h00);
            default:  key_wr = 1'b0;
         endcase
      end
   end

   assign cfg_wr_en = (lock_q == UNLOCKED);

   always_ff @(posedge clock) begin
      if (reset) begin
         lock_q <= LOCKED;
      end else if (commit) begin
         case (lock_q)
            LOCKED:   if (key_wr) lock_q <= KEY1;
            KEY1:     lock_q <= key_wr ? UNLOCKED : LOCKED;
            UNLOCKED: if (key_wr) lock_q <= LOCKED;
            default:  lock_q <= LOCKED;
         endcase
      end
   end
`else
   assign key_wr    = 1'b0;
   assign cfg_wr_en = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         phi2_m    <= 1'b0;
         phi2_s    <= 1'b0;
         phi2_d    <= 1'b0;
         hold_addr <= '0;
         hold_data <= '0;
         hold_rw   <= 1'b0;
         ctrl_q    <= '0;
         hidden    <= 1'b0;
         mode_q    <= 8'hFF;
         bank_q[0] <= BANK_W'(1);
         bank_q[1] <= BANK_W'(2);
         bank_q[2] <= BANK_W'(3);
         bank_q[3] <= BANK_W'(5);
         scratch_q <= '0;
      end else begin
         phi2_m <= phi2_cpu;
         phi2_s <= phi2_m;
         phi2_d <= phi2_s;
         // keep overwriting while phi2 is high so the last sample before the fall wins
         if (phi2_s) begin
            hold_addr <= address_cpu;
            hold_data <= data_cpu_in;
            hold_rw   <= r_w_cpu;
         end
         if (commit) begin
            case (wsel)
               3'd0: begin
                  if (!key_wr) begin
                     ctrl_q <= hold_data[6:0];
                     if (hold_data[7]) hidden <= 1'b1;
                  end
               end
               3'd2: if (cfg_wr_en) mode_q <= hold_data;
               3'd3, 3'd4, 3'd5, 3'd6: if (cfg_wr_en) bank_q[bank_wsel] <= hold_data[BANK_W-1:0];
               3'd7: if (cfg_wr_en) scratch_q <= hold_data;
               default: ;
            endcase
         end
      end
   end

   assign win_hit     = (address_cpu[15:3] == REG_BASE[15:3]);
   assign data_reg_oe = phi2_cpu & r_w_cpu & win_hit & ~hidden & ~reset;

   always_comb begin
      data_reg_out = 8'h00;
      if (data_reg_oe) begin
         case (address_cpu[2:0])
            3'd0:    data_reg_out = {1'b0, ctrl_q};
            3'd1:    data_reg_out = ID_VALUE;
            3'd2:    data_reg_out = mode_q;
            3'd7:    data_reg_out = scratch_q;
            default: data_reg_out = 8'(bank_q[address_cpu[1:0] + 2'd1]);
         endcase
      end
   end

   always_comb begin
      blk_vld = 1'b1;
      blk_sel = 2'd0;
      case (address_cpu[15:13])
         3'd1:    blk_sel = 2'd0;
         3'd2:    blk_sel = 2'd1;
         3'd3:    blk_sel = 2'd2;
         3'd5:    blk_sel = 2'd3;
         default: blk_vld = 1'b0;
      endcase
      blk_mode = mode_q[{blk_sel, 1'b0} +: 2];
      map_rom  = blk_vld & (blk_mode == 2'b01);
      map_ram  = blk_vld & blk_mode[1];
      map_wp   = blk_vld & (blk_mode == 2'b10);
      map_bank = blk_vld ? bank_q[blk_sel] : '0;
   end

endmodule

// File: tb/tb_ultimem_cfg_regs.sv
// Randomised and directed bench for ultimem_cfg_regs against a register-array reference model.
module tb_ultimem_cfg_regs;

   localparam logic [15:0] REG_BASE = 16'h9FF0;
   localparam logic [7:0]  ID_VALUE = 8'h11;
   localparam int          BANK_W   = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              phi2_cpu;
   logic [15:0]       address_cpu;
   logic [7:0]        data_cpu_in;
   logic              r_w_cpu;
   logic [7:0]        data_reg_out;
   logic              data_reg_oe;
   logic              map_ram, map_rom, map_wp;
   logic [BANK_W-1:0] map_bank;
   logic              hidden;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] mregs [8];
   logic       mhidden;
   int         mlock;

   ultimem_cfg_regs #(.ID_VALUE(ID_VALUE), .REG_BASE(REG_BASE), .BANK_W(BANK_W)) dut (
      .clock(clk), .reset(reset), .phi2_cpu(phi2_cpu), .address_cpu(address_cpu),
      .data_cpu_in(data_cpu_in), .r_w_cpu(r_w_cpu), .data_reg_out(data_reg_out),
      .data_reg_oe(data_reg_oe), .map_ram(map_ram), .map_rom(map_rom), .map_wp(map_wp),
      .map_bank(map_bank), .hidden(hidden)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      mregs[0] = 8'h00; mregs[1] = ID_VALUE; mregs[2] = 8'hFF; mregs[3] = 8'h01;
      mregs[4] = 8'h02; mregs[5] = 8'h03;    mregs[6] = 8'h05; mregs[7] = 8'h00;
      mhidden = 1'b0;
      mlock   = 0;
   endfunction

   function automatic bit in_window(input logic [15:0] a);
      return (a >> 3) == (REG_BASE >> 3);
   endfunction

   function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
      int idx;
      bit key;
      if (!in_window(a) || mhidden) return;
      idx = int'(a & 16'h7);
      key = 1'b0;
`ifdef UNLOCK_SEQ_EN
      if (idx == 0) begin
         if (mlock == 0 && d == 8'hA5) begin mlock = 1; key = 1'b1; end
         else if (mlock == 1) begin
            if (d == 8'h5A) begin mlock = 2; key = 1'b1; end
            else mlock = 0;
         end
         else if (mlock == 2 && d == 8'h00) begin mlock = 0; key = 1'b1; end
      end else begin
         if (mlock == 1) mlock = 0;
         if (idx >= 2 && mlock != 2) return;
      end
`endif
      if (idx == 0) begin
         if (!key) begin
            mregs[0] = d & 8'h7F;
            if (d >= 8'h80) mhidden = 1'b1;
         end
      end else if (idx >= 3 && idx <= 6) begin
         mregs[idx] = d & 8'((1 << BANK_W) - 1);
      end else if (idx != 1) begin
         mregs[idx] = d;
      end
   endfunction

   task automatic chk_map(input logic [15:0] a);
      int k;
      int m;
      address_cpu = a;
      #1;
      case (a / 16'h2000)
         1: k = 0;
         2: k = 1;
         3: k = 2;
         5: k = 3;
         default: k = -1;
      endcase
      if (k < 0) begin
         chk("map_rom", map_rom, 0); chk("map_ram", map_ram, 0);
         chk("map_wp", map_wp, 0);   chk("map_bank", map_bank, 0);
      end else begin
         m = (int'(mregs[2]) >> (2 * k)) % 4;
         chk("map_rom", map_rom, m == 1);
         chk("map_ram", map_ram, m >= 2);
         chk("map_wp", map_wp, m == 2);
         chk("map_bank", map_bank, mregs[3 + k]);
      end
   endtask

   task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
      logic exp_oe;
      address_cpu = a; r_w_cpu = rw; data_cpu_in = d; phi2_cpu = 1'b1;
      step(4);
      if (rw) begin
         exp_oe = in_window(a) && !mhidden;
         chk("rd_oe", data_reg_oe, exp_oe);
         chk("rd_dat", data_reg_out, exp_oe ? mregs[a % 8] : 8'h00);
      end
      step(2);
      phi2_cpu = 1'b0;
      step(5);
      if (!rw) model_write(a, d);
      chk("hidden", hidden, mhidden);
   endtask

   task automatic do_reset();
      phi2_cpu = 1'b0;
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      model_reset();
      step(2);
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        rw;

      reset = 1'b1; phi2_cpu = 1'b1; r_w_cpu = 1'b1; address_cpu = 16'h9FF1; data_cpu_in = 8'h00;
      model_reset();
      step(3);
      chk("rst_oe", data_reg_oe, 0);
      chk("rst_dat", data_reg_out, 0);
      chk("rst_hidden", hidden, 0);
      phi2_cpu = 1'b0;
      step(3);
      reset = 1'b0;
      step(2);

      cpu_cycle(16'h9FF1, 1'b1, 8'h00);
      cpu_cycle(16'h9FF2, 1'b1, 8'h00);
      chk_map(16'hA000);
      chk("rst_bank5", map_bank, 6'h05);

      // write BANK5 and MODE, then watch a MODE write land in the expected window
      cpu_cycle(16'h9FF6, 1'b0, 8'h2A);
      cpu_cycle(16'h9FF2, 1'b0, 8'h7F);
      chk_map(16'hBFFF);
      address_cpu = 16'h9FF2; r_w_cpu = 1'b0; data_cpu_in = 8'hBF; phi2_cpu = 1'b1;
      step(6);
      phi2_cpu = 1'b0;
      step(2);
      chk_map(16'hBFFF);
      step(2);
      model_write(16'h9FF2, 8'hBF);
      chk_map(16'hBFFF);
      chk("lat_wp", map_wp, 1);
      chk("lat_bank", map_bank, 6'h2A);

      cpu_cycle(16'h9FF2, 1'b0, 8'h01);
      chk_map(16'h2000);
      chk("blk1_rom", map_rom, 1);
      chk_map(16'h4000);
      chk_map(16'hC000);
      chk_map(16'h0400);

      cpu_cycle(16'h9FF0, 1'b0, 8'h80);
      chk("hide_set", hidden, 1);
      cpu_cycle(16'h9FF7, 1'b0, 8'h33);
      cpu_cycle(16'h9FF7, 1'b1, 8'h00);
      chk("hide_oe", data_reg_oe, 0);
      chk_map(16'h2000);
      do_reset();
      cpu_cycle(16'h9FF7, 1'b1, 8'h00);

      // reset coincides with the clock that would commit a BANK1 write
      address_cpu = 16'h9FF3; r_w_cpu = 1'b0; data_cpu_in = 8'h3F; phi2_cpu = 1'b1;
      step(6);
      phi2_cpu = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      model_reset();
      step(4);
      chk_map(16'h2000);
      chk("rstfall_bank1", map_bank, 6'h01);

      // phi2 stuck high: nothing commits however long it stays there
      address_cpu = 16'h9FF7; r_w_cpu = 1'b0; data_cpu_in = 8'h77; phi2_cpu = 1'b1;
      step(40);
      r_w_cpu = 1'b1;
      #1;
      chk("stuck_hi", data_reg_out, mregs[7]);
      step(4);
      phi2_cpu = 1'b0;
      step(5);
      cpu_cycle(16'h9FF7, 1'b1, 8'h00);

`ifdef UNLOCK_SEQ_EN
      do_reset();
      cpu_cycle(16'h9FF3, 1'b0, 8'h10);
      cpu_cycle(16'h9FF3, 1'b1, 8'h00);
      chk("lock_bank1", data_reg_out, 8'h01);
      cpu_cycle(16'h9FF0, 1'b0, 8'hA5);
      cpu_cycle(16'h9FF0, 1'b0, 8'h5A);
      cpu_cycle(16'h9FF3, 1'b0, 8'h10);
      cpu_cycle(16'h9FF3, 1'b1, 8'h00);
      chk("unlock_bank1", data_reg_out, 8'h10);
      cpu_cycle(16'h9FF0, 1'b0, 8'h00);
      cpu_cycle(16'h9FF4, 1'b0, 8'h11);
      cpu_cycle(16'h9FF4, 1'b1, 8'h00);
      do_reset();
      cpu_cycle(16'h9FF0, 1'b0, 8'hA5);
      cpu_cycle(16'h9FF0, 1'b0, 8'h00);
      cpu_cycle(16'h9FF4, 1'b0, 8'h11);
      cpu_cycle(16'h9FF4, 1'b1, 8'h00);
      chk("badkey_bank2", data_reg_out, 8'h02);
`endif

      for (int i = 0; i < 150; i++) begin
         if (i % 25 == 24) do_reset();
         if ($urandom_range(1, 0) == 1) a = REG_BASE | 16'($urandom_range(7, 0));
         else a = 16'($urandom);
         rw = 1'($urandom_range(1, 0));
         d  = 8'($urandom);
         if (in_window(a) && a[2:0] == 3'd0 && $urandom_range(3, 0) != 0) d[7] = 1'b0;
         cpu_cycle(a, rw, d);
         chk_map(16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
